// File: rtl/bg_fetcher.sv
// Background tile fetcher: walks map -> tile-lo -> tile-hi for one scanline and
// streams 2-bit colour indices out of a 16-entry pixel FIFO with valid/ready.
module bg_fetcher #(
  parameter int LINE_PIXELS = 160
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  LY,
  input  logic [7:0]  SCX,
  input  logic [7:0]  SCY,
  input  logic        bg_map_sel,
  input  logic        tile_data_sel,
  output logic [12:0] ppu_addr,
  output logic        ppu_vram_read_en,
  output logic        ppu_read_mode,
  input  logic [7:0]  ppu_data_in,
  output logic [1:0]  pix_out,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        line_done,
  output logic [2:0]  fsm_state,
  output logic [4:0]  fifo_level
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAP_A = 3'd1;
  localparam logic [2:0] S_MAP_D = 3'd2;
  localparam logic [2:0] S_LO_A  = 3'd3;
  localparam logic [2:0] S_LO_D  = 3'd4;
  localparam logic [2:0] S_HI_A  = 3'd5;
  localparam logic [2:0] S_HI_D  = 3'd6;
  localparam logic [2:0] S_PUSH  = 3'd7;

  localparam int PXW = $clog2(LINE_PIXELS + 1);

  logic [2:0]     state;
  logic [7:0]     ly_q, scx_q, scy_q;
  logic           map_sel_q, data_sel_q;
  logic [4:0]     tile_x;
  logic [PXW-1:0] pixel_x;
  logic [2:0]     discard;
  logic [7:0]     tile_q, lo_q, hi_q;
  logic [1:0]     fifo_mem [16];
  logic [3:0]     rd_ptr, wr_ptr;
  logic [4:0]     count;

  logic [7:0]  row;
  logic [4:0]  map_col;
  logic [12:0] map_addr, tile_base, lo_addr, hi_addr;
  logic        active, drop, take, last, push, pop;

  // Valid/ready: a pixel moves when pix_valid and pix_ready are both high at a
  // rising edge; pix_out is held stable while pix_valid is high and not taken.
  assign active    = (state != S_IDLE);
  assign pix_valid = active && (discard == 3'd0) && (count != 5'd0);
  assign drop      = active && (discard != 3'd0) && (count != 5'd0);
  assign take      = pix_valid && pix_ready;
  assign last      = take && (pixel_x == PXW'(LINE_PIXELS - 1));
  assign push      = (state == S_PUSH) && (count <= 5'd8);
  assign pop       = drop || take;

  assign pix_out          = pix_valid ? fifo_mem[rd_ptr] : 2'b00;
  assign ppu_vram_read_en = active;
  assign ppu_read_mode    = active;
  assign fsm_state        = state;
  assign fifo_level       = count;

  assign row       = ly_q + scy_q;
  assign map_col   = tile_x + scx_q[7:3];
  assign map_addr  = (map_sel_q ? 13'h1C00 : 13'h1800) + {3'b000, row[7:3], 5'b00000}
                     + {8'h00, map_col};
  // Signed addressing: sign-extend tile*16 to 13 bits; the sum wraps inside VRAM.
  assign tile_base = data_sel_q ? {1'b0, tile_q, 4'b0000}
                                : 13'h1000 + {tile_q[7], tile_q, 4'b0000};
  assign lo_addr   = tile_base + {9'h000, row[2:0], 1'b0};
  assign hi_addr   = lo_addr + 13'd1;

  always_comb begin
    ppu_addr = 13'h0000;
    case (state)
      S_MAP_A, S_MAP_D: ppu_addr = map_addr;
      S_LO_A, S_LO_D:   ppu_addr = lo_addr;
      S_HI_A, S_HI_D:   ppu_addr = hi_addr;
      default:          ppu_addr = 13'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ly_q       <= 8'h00;
      scx_q      <= 8'h00;
      scy_q      <= 8'h00;
      map_sel_q  <= 1'b0;
      data_sel_q <= 1'b0;
      tile_x     <= 5'd0;
      pixel_x    <= '0;
      discard    <= 3'd0;
      tile_q     <= 8'h00;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      rd_ptr     <= 4'd0;
      wr_ptr     <= 4'd0;
      count      <= 5'd0;
      line_done  <= 1'b0;
    end else begin
      line_done <= last;
      if (state == S_IDLE) begin
        if (start) begin
          ly_q       <= LY;
          scx_q      <= SCX;
          scy_q      <= SCY;
          map_sel_q  <= bg_map_sel;
          data_sel_q <= tile_data_sel;
          tile_x     <= 5'd0;
          pixel_x    <= '0;
          discard    <= SCX[2:0];
          rd_ptr     <= 4'd0;
          wr_ptr     <= 4'd0;
          count      <= 5'd0;
          state      <= S_MAP_A;
        end
      end else if (last) begin
        state  <= S_IDLE;
        rd_ptr <= 4'd0;
        wr_ptr <= 4'd0;
        count  <= 5'd0;
      end else begin
        case (state)
          S_MAP_A: state <= S_MAP_D;
          S_MAP_D: begin
            tile_q <= ppu_data_in;
            state  <= S_LO_A;
          end
          S_LO_A: state <= S_LO_D;
          S_LO_D: begin
            lo_q  <= ppu_data_in;
            state <= S_HI_A;
          end
          S_HI_A: state <= S_HI_D;
          S_HI_D: begin
            hi_q  <= ppu_data_in;
            state <= S_PUSH;
          end
          S_PUSH: begin
            if (push) begin
              wr_ptr <= wr_ptr + 4'd8;
              tile_x <= tile_x + 5'd1;
              state  <= S_MAP_A;
            end
          end
          default: state <= S_IDLE;
        endcase
        if (pop)  rd_ptr  <= rd_ptr + 4'd1;
        if (drop) discard <= discard - 3'd1;
        if (take) pixel_x <= pixel_x + PXW'(1);
        count <= count + (push ? 5'd8 : 5'd0) - (pop ? 5'd1 : 5'd0);
      end
    end
  end

  // Pixel storage carries no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < 8; i++) begin
        fifo_mem[wr_ptr + 4'(i)] <= {hi_q[7-i], lo_q[7-i]};
      end
    end
  end

endmodule
